// File: rtl/lsu_commit_arb.sv
// lsu_commit_arb: merges LSU load and store commit beats into one commit port through a 2-entry output FIFO.
// Build option LSU_COMMIT_LDPRIO_EN: fixed load-over-store priority replaces round-robin.
module lsu_commit_arb #(
    parameter int CORE_ID     = 0,
    parameter int UUID_BITS   = 8,
    parameter int NW_BITS     = 2,
    parameter int NUM_THREADS = 4,
    parameter int NR_BITS     = 5
) (
    input  logic                      clk,
    input  logic                      reset,

    // Handshake on every port: a beat transfers in a cycle where valid and ready are both 1;
    // the source holds valid and payload stable until that cycle.
    input  logic                      ld_commit_valid,
    output logic                      ld_commit_ready,
    input  logic [UUID_BITS-1:0]      ld_commit_uuid,
    input  logic [NW_BITS-1:0]        ld_commit_wid,
    input  logic [NUM_THREADS-1:0]    ld_commit_tmask,
    input  logic [31:0]               ld_commit_pc,
    input  logic [NR_BITS-1:0]        ld_commit_rd,
    input  logic                      ld_commit_wb,
    input  logic                      ld_commit_eop,
    input  logic [NUM_THREADS*32-1:0] ld_commit_data,

    input  logic                      st_commit_valid,
    output logic                      st_commit_ready,
    input  logic [UUID_BITS-1:0]      st_commit_uuid,
    input  logic [NW_BITS-1:0]        st_commit_wid,
    input  logic [NUM_THREADS-1:0]    st_commit_tmask,
    input  logic [31:0]               st_commit_pc,
    input  logic [NR_BITS-1:0]        st_commit_rd,
    input  logic                      st_commit_wb,
    input  logic                      st_commit_eop,
    input  logic [NUM_THREADS*32-1:0] st_commit_data,

    output logic                      commit_valid,
    input  logic                      commit_ready,
    output logic [UUID_BITS-1:0]      commit_uuid,
    output logic [NW_BITS-1:0]        commit_wid,
    output logic [NUM_THREADS-1:0]    commit_tmask,
    output logic [31:0]               commit_pc,
    output logic [NR_BITS-1:0]        commit_rd,
    output logic                      commit_wb,
    output logic                      commit_eop,
    output logic [NUM_THREADS*32-1:0] commit_data,

    output logic [1:0]                dbg_count,
    output logic                      dbg_lock,
    output logic                      dbg_last
);

    localparam int PW = UUID_BITS + NW_BITS + NUM_THREADS + 32 + NR_BITS + 2 + NUM_THREADS*32;

    logic [PW-1:0] ld_pl, st_pl, push_pl, head_pl;
    logic [PW-1:0] mem [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    count;
    logic          space, push, pop, ld_fire, st_fire;
    logic          grant_ld, grant_st;
    logic          lock, lock_n, last;

    assign ld_pl = {ld_commit_uuid, ld_commit_wid, ld_commit_tmask, ld_commit_pc,
                    ld_commit_rd, ld_commit_wb, ld_commit_eop, ld_commit_data};
    assign st_pl = {st_commit_uuid, st_commit_wid, st_commit_tmask, st_commit_pc,
                    st_commit_rd, st_commit_wb, st_commit_eop, st_commit_data};

    // Space comes from the registered count only, so a stalled output never reaches the LSU readys.
    assign space   = (count != 2'd2);
    assign ld_fire = ld_commit_valid & ld_commit_ready;
    assign st_fire = st_commit_valid & st_commit_ready;
    assign push    = ld_fire | st_fire;
    assign push_pl = ld_fire ? ld_pl : st_pl;
    assign pop     = commit_valid & commit_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock <= 1'b0;
        end else begin
            lock <= lock_n;
        end
    end

    always_comb begin
        lock_n = lock;
        if (ld_fire) begin
            lock_n = ~ld_commit_eop;
        end
    end

`ifdef LSU_COMMIT_LDPRIO_EN
    assign last = 1'b0;
`else
    logic last_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= 1'b0;
        end else begin
            last <= last_n;
        end
    end

    always_comb begin
        last_n = last;
        if (ld_fire) begin
            last_n = 1'b1;
        end else if (st_fire) begin
            last_n = 1'b0;
        end
    end
`endif

    always_comb begin
        grant_ld = 1'b0;
        grant_st = 1'b0;
        if (lock) begin
            grant_ld = 1'b1;
        end else if (ld_commit_valid && st_commit_valid) begin
`ifdef LSU_COMMIT_LDPRIO_EN
            grant_ld = 1'b1;
`else
            grant_ld = ~last;
            grant_st = last;
`endif
        end else begin
            grant_ld = ld_commit_valid;
            grant_st = st_commit_valid;
        end
    end

    assign ld_commit_ready = reset & space & grant_ld;
    assign st_commit_ready = reset & space & grant_st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_pl;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_pl      = mem[rd_ptr];
    assign commit_valid = (count != 2'd0);
    assign {commit_uuid, commit_wid, commit_tmask, commit_pc,
            commit_rd, commit_wb, commit_eop, commit_data} = head_pl;

    assign dbg_count = count;
    assign dbg_lock  = lock;
    assign dbg_last  = last;

    // Simulation-only protocol checks.
    st_eop_chk: assert property (@(posedge clk) disable iff (!reset) st_commit_valid |-> st_commit_eop)
        else $error("lsu_commit_arb[%0d]: store commit beat without eop", CORE_ID);
    ovf_chk: assert property (@(posedge clk) disable iff (!reset) push |-> (count != 2'd2))
        else $error("lsu_commit_arb[%0d]: push into full output buffer", CORE_ID);

endmodule

// File: tb/tb_lsu_commit_arb.sv
// tb_lsu_commit_arb: randomized and directed stimulus for lsu_commit_arb against a queue-based reference model.
`timescale 1ns/1ps
module tb_lsu_commit_arb;
  localparam int UB = 8;
  localparam int NWB = 2;
  localparam int NT = 4;
  localparam int NRB = 5;
  localparam int DW = NT * 32;
  localparam int PW = UB + NWB + NT + 32 + NRB + 2 + DW;
  localparam int EOP_BIT = DW;
  localparam int SRC_BIT = PW - 1;  // uuid MSB: 1 marks a store beat

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic ld_valid = 1'b0, st_valid = 1'b0, out_ready = 1'b0;
  logic ld_ready, st_ready, out_valid;
  logic [PW-1:0] ld_pl = '0, st_pl = '0, out_pl;

  logic [UB-1:0] ld_uuid, st_uuid, o_uuid;
  logic [NWB-1:0] ld_wid, st_wid, o_wid;
  logic [NT-1:0] ld_tmask, st_tmask, o_tmask;
  logic [31:0] ld_pc, st_pc, o_pc;
  logic [NRB-1:0] ld_rd, st_rd, o_rd;
  logic ld_wb, st_wb, o_wb, ld_eop, st_eop, o_eop;
  logic [DW-1:0] ld_data, st_data, o_data;
  logic [1:0] dbg_count;
  logic dbg_lock, dbg_last;

  assign {ld_uuid, ld_wid, ld_tmask, ld_pc, ld_rd, ld_wb, ld_eop, ld_data} = ld_pl;
  assign {st_uuid, st_wid, st_tmask, st_pc, st_rd, st_wb, st_eop, st_data} = st_pl;
  assign out_pl = {o_uuid, o_wid, o_tmask, o_pc, o_rd, o_wb, o_eop, o_data};

  lsu_commit_arb #(
    .CORE_ID(0), .UUID_BITS(UB), .NW_BITS(NWB), .NUM_THREADS(NT), .NR_BITS(NRB)
  ) dut (
    .clk(clk), .reset(reset),
    .ld_commit_valid(ld_valid), .ld_commit_ready(ld_ready),
    .ld_commit_uuid(ld_uuid), .ld_commit_wid(ld_wid), .ld_commit_tmask(ld_tmask),
    .ld_commit_pc(ld_pc), .ld_commit_rd(ld_rd), .ld_commit_wb(ld_wb),
    .ld_commit_eop(ld_eop), .ld_commit_data(ld_data),
    .st_commit_valid(st_valid), .st_commit_ready(st_ready),
    .st_commit_uuid(st_uuid), .st_commit_wid(st_wid), .st_commit_tmask(st_tmask),
    .st_commit_pc(st_pc), .st_commit_rd(st_rd), .st_commit_wb(st_wb),
    .st_commit_eop(st_eop), .st_commit_data(st_data),
    .commit_valid(out_valid), .commit_ready(out_ready),
    .commit_uuid(o_uuid), .commit_wid(o_wid), .commit_tmask(o_tmask),
    .commit_pc(o_pc), .commit_rd(o_rd), .commit_wb(o_wb),
    .commit_eop(o_eop), .commit_data(o_data),
    .dbg_count(dbg_count), .dbg_lock(dbg_lock), .dbg_last(dbg_last)
  );

  // ---------------- scoreboard state / reference model ----------------
  int n_tests = 0;
  int n_fail = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] mbuf[$];
  logic [PW-1:0] ld_pend[$];
  logic [PW-1:0] st_pend[$];
  bit m_lock = 1'b0, m_last = 1'b0;
  bit ld_hold = 1'b0, st_hold = 1'b0;
  bit gen = 1'b0;
  int ld_pct = 0, st_pct = 0, rdy_pct = 100;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] make_beat(input bit is_st, input bit eop);
    logic [UB-1:0] u;
    logic [DW-1:0] d;
    u = UB'($urandom);
    u[UB-1] = is_st;
    d = {$urandom, $urandom, $urandom, $urandom};
    return {u, NWB'($urandom), NT'($urandom), 32'($urandom), NRB'($urandom), 1'($urandom), eop, d};
  endfunction

  // Reference: buffer occupancy as a queue, grants from lock / last-served rules.
  task automatic model_step();
    bit sp, g_ld, g_st, f_ld, f_st;
    check("count", PW'(dbg_count), PW'(mbuf.size()));
    check("lock", PW'(dbg_lock), PW'(m_lock));
    check("out_valid", PW'(out_valid), PW'(mbuf.size() != 0));
    sp = (mbuf.size() != 2);
    g_ld = 1'b0;
    g_st = 1'b0;
    if (m_lock) g_ld = 1'b1;
    else if (ld_valid && st_valid) begin
`ifdef LSU_COMMIT_LDPRIO_EN
      g_ld = 1'b1;
`else
      g_ld = !m_last;
      g_st = m_last;
`endif
    end else begin
      g_ld = ld_valid;
      g_st = st_valid;
    end
    check("ld_ready", PW'(ld_ready), PW'(sp & g_ld));
    check("st_ready", PW'(st_ready), PW'(sp & g_st));
    f_ld = ld_valid && sp && g_ld;
    f_st = st_valid && sp && g_st;
    if (mbuf.size() != 0 && out_ready) void'(mbuf.pop_front());
    if (f_ld) begin
      mbuf.push_back(ld_pl);
      exp_q.push_back(ld_pl);
      m_last = 1'b1;
      m_lock = !ld_pl[EOP_BIT];
      ld_hold = 1'b0;
      void'(ld_pend.pop_front());
    end else if (f_st) begin
      mbuf.push_back(st_pl);
      exp_q.push_back(st_pl);
      m_last = 1'b0;
      st_hold = 1'b0;
      void'(st_pend.pop_front());
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    @(negedge clk);
    if (gen) begin
      if (ld_pend.size() == 0) begin
        int n;
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) ld_pend.push_back(make_beat(1'b0, i == n - 1));
      end
      if (st_pend.size() == 0) st_pend.push_back(make_beat(1'b1, 1'b1));
    end
    if (!ld_hold && ld_pend.size() != 0 && $urandom_range(99) < ld_pct) ld_hold = 1'b1;
    if (!st_hold && st_pend.size() != 0 && $urandom_range(99) < st_pct) st_hold = 1'b1;
    ld_valid = ld_hold;
    ld_pl = ld_hold ? ld_pend[0] : '0;
    st_valid = st_hold;
    st_pl = st_hold ? st_pend[0] : '0;
    out_ready = ($urandom_range(99) < rdy_pct);
    #1;
    model_step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- monitor ----------------
  bit stalled = 1'b0, in_pkt = 1'b0;
  logic [PW-1:0] held_pl = '0;

  initial forever begin
    @(negedge clk);
    #2;
    if (!reset) begin
      stalled = 1'b0;
      in_pkt = 1'b0;
    end else begin
      if (stalled && out_valid) check("hold", out_pl, held_pl);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected none", out_pl);
        end else begin
          check("payload", out_pl, exp_q.pop_front());
        end
        check("no_interleave", PW'(out_pl[SRC_BIT] && in_pkt), '0);
        in_pkt = !out_pl[SRC_BIT] && !out_pl[EOP_BIT];
      end
      stalled = out_valid && !out_ready;
      held_pl = out_pl;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int stall_fires;
    bit drained;
    // Reset held with both inputs valid: readys must stay low.
    ld_valid = 1'b1;
    st_valid = 1'b1;
    ld_pl = make_beat(1'b0, 1'b1);
    st_pl = make_beat(1'b1, 1'b1);
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", PW'(out_valid), '0);
    check("rst_payload", out_pl, '0);
    check("rst_ld_ready", PW'(ld_ready), '0);
    check("rst_st_ready", PW'(st_ready), '0);
    check("rst_count", PW'(dbg_count), '0);
    @(negedge clk);
    ld_valid = 1'b0;
    st_valid = 1'b0;
    reset = 1'b1;

    // Single store, one-cycle latency.
    st_pend.push_back({UB'(5), NWB'(2), NT'(4'hf), 32'h8000_0010, NRB'(3), 1'b1, 1'b1, DW'(128'h1234)});
    st_pct = 100; ld_pct = 0; rdy_pct = 100;
    cycle();
    check("s1_st_ready", PW'(st_ready), PW'(1));
    cycle();
    check("s1_valid", PW'(out_valid), PW'(1));
    check("s1_wid", PW'(o_wid), PW'(2));
    check("s1_pc", PW'(o_pc), PW'(32'h8000_0010));
    check("s1_uuid", PW'(o_uuid), PW'(5));
    check("s1_eop", PW'(o_eop), PW'(1));
    run(2);

    // 3-beat load packet with a store waiting, then a second contention.
    ld_pend.push_back(make_beat(1'b0, 1'b0));
    ld_pend.push_back(make_beat(1'b0, 1'b0));
    ld_pend.push_back(make_beat(1'b0, 1'b1));
    ld_pend.push_back(make_beat(1'b0, 1'b1));
    st_pend.push_back(make_beat(1'b1, 1'b1));
    st_pend.push_back(make_beat(1'b1, 1'b1));
    ld_pct = 100; st_pct = 100;
    run(10);

    // Single-beat loads and stores both always valid.
    for (int i = 0; i < 6; i++) begin
      ld_pend.push_back(make_beat(1'b0, 1'b1));
      st_pend.push_back(make_beat(1'b1, 1'b1));
    end
    run(16);

    // Output stalled for 5 cycles with loads streaming.
    for (int i = 0; i < 8; i++) ld_pend.push_back(make_beat(1'b0, 1'b1));
    st_pct = 0; rdy_pct = 0;
    stall_fires = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (ld_valid && ld_ready) stall_fires++;
    end
    check("stall_absorbed", PW'(stall_fires), PW'(2));
    check("stall_ld_ready", PW'(ld_ready), '0);
    rdy_pct = 100;
    run(12);

    // Asynchronous reset in the middle of a 2-beat load packet.
    ld_pend.push_back(make_beat(1'b0, 1'b0));
    ld_pend.push_back(make_beat(1'b0, 1'b1));
    ld_pct = 100; rdy_pct = 0;
    cycle();
    @(negedge clk);
    ld_valid = 1'b0;
    st_valid = 1'b0;
    out_ready = 1'b0;
    check("pre_rst_lock", PW'(dbg_lock), PW'(1));
    #3;
    reset = 1'b0;
    #1;
    check("midrst_out_valid", PW'(out_valid), '0);
    check("midrst_ld_ready", PW'(ld_ready), '0);
    mbuf.delete(); exp_q.delete(); ld_pend.delete(); st_pend.delete();
    m_lock = 1'b0; m_last = 1'b0; ld_hold = 1'b0; st_hold = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    st_pend.push_back(make_beat(1'b1, 1'b1));
    ld_pct = 0; st_pct = 100; rdy_pct = 100;
    cycle();
    check("post_rst_lock", PW'(dbg_lock), '0);
    check("post_rst_st_ready", PW'(st_ready), PW'(1));
    run(3);

    // Random traffic on all three ports.
    gen = 1'b1;
    for (int blk = 0; blk < 10; blk++) begin
      ld_pct = $urandom_range(20, 100);
      st_pct = $urandom_range(20, 100);
      rdy_pct = $urandom_range(20, 100);
      run(1000);
    end

    // Drain everything still pending.
    gen = 1'b0;
    ld_pct = 100; st_pct = 100; rdy_pct = 100;
    drained = 1'b0;
    for (int i = 0; i < 300 && !drained; i++) begin
      cycle();
      drained = (ld_pend.size() == 0 && st_pend.size() == 0 && mbuf.size() == 0);
    end
    if (!drained) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got pending beats expected none");
    end
    #5;
    check("exp_q_empty", PW'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
